// File: rtl/i2c_slave_tx_byte_ctrl_pkg.sv
// Shared definitions for the I2C slave transmit byte controller:
// FSM encoding, SDA drive levels and default sizing.
package i2c_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_ACK   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT,
        ACK   = ST_ACK,
        DONE  = ST_DONE
    } state_t;

    localparam logic SDA_RELEASE   = 1'b1;
    localparam logic SDA_DRIVE_LOW = 1'b0;

    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_DATA_WIDTH  = 8;

endpackage

// File: rtl/i2c_slave_tx_byte_ctrl_if.sv
// Control bundle between the slave protocol FSM (master side)
// and the transmit byte controller (slave side).
interface i2c_slave_tx_byte_ctrl_if
    import i2c_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

    logic                  go;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  abort;
    logic                  busy;
    logic                  finish;
    logic                  ack_ok;

    modport master (
        output go, data_in, abort,
        input  busy, finish, ack_ok
    );

    modport slave (
        input  go, data_in, abort,
        output busy, finish, ack_ok
    );

endinterface

// File: rtl/i2c_slave_tx_byte_ctrl_sync_edge.sv
// Pin synchroniser with one history flop; flags edges of the
// synchronised level. Flops reset to 1 (idle bus level).
module i2c_sync_edge
    import i2c_pkg::*;
#(
    parameter int STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic clock,
    input  logic reset_n,
    input  logic in,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              hist;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '1;
            hist  <= 1'b1;
        end else begin
            chain <= {chain[STAGES-2:0], in};
            hist  <= chain[STAGES-1];
        end
    end

    assign sync = chain[STAGES-1];
    assign rise = ~hist & sync;
    assign fall = hist & ~sync;

endmodule

// File: rtl/i2c_slave_tx_byte_ctrl.sv
// Slave-transmit byte sequencer: shifts a latched byte out MSB
// first on SCL falls, then samples the master ACK on the 9th rise.
module i2c_slave_tx_byte_ctrl
    import i2c_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                       clock,
    input  logic                       reset_n,
    i2c_slave_tx_byte_ctrl_if.slave    ctrl,
    input  logic                       scl,
    input  logic                       sda_in,
    output logic                       sda_out
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    logic scl_sync_unused;
    logic scl_rise;
    logic scl_fall;
    logic sda_sync;
    logic sda_rise_unused;
    logic sda_fall_unused;

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .in      (scl),
        .sync    (scl_sync_unused),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    // SDA uses the same depth so the ACK level lines up with the SCL rise flag
    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .in      (sda_in),
        .sync    (sda_sync),
        .rise    (sda_rise_unused),
        .fall    (sda_fall_unused)
    );

    state_t                state,    state_n;
    logic [DATA_WIDTH-1:0] shreg,    shreg_n;
    logic [CW-1:0]         cnt,      cnt_n;
    logic                  sda_q,    sda_n;
    logic                  busy_q,   busy_n;
    logic                  finish_q, finish_n;
    logic                  ack_q,    ack_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            shreg    <= '0;
            cnt      <= '0;
            sda_q    <= SDA_RELEASE;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            cnt      <= cnt_n;
            sda_q    <= sda_n;
            busy_q   <= busy_n;
            finish_q <= finish_n;
            ack_q    <= ack_n;
        end
    end

    always_comb begin
        state_n  = state;
        shreg_n  = shreg;
        cnt_n    = cnt;
        sda_n    = sda_q;
        busy_n   = busy_q;
        finish_n = 1'b0;
        ack_n    = ack_q;

        unique case (state)
            IDLE: begin
                sda_n = SDA_RELEASE;
                if (ctrl.go) begin
                    shreg_n = ctrl.data_in;
                    cnt_n   = CW'(DATA_WIDTH);
                    busy_n  = 1'b1;
                    ack_n   = 1'b0;
                    state_n = SHIFT;
                end
            end
            SHIFT: begin
                // The extra fall after the last bit hands SDA to the master
                if (scl_fall) begin
                    if (cnt == '0) begin
                        sda_n   = SDA_RELEASE;
                        state_n = ACK;
                    end else begin
                        sda_n   = shreg[DATA_WIDTH-1];
                        shreg_n = shreg << 1;
                        cnt_n   = cnt - CW'(1);
                    end
                end
            end
            ACK: begin
                if (scl_rise) begin
                    ack_n    = ~sda_sync;
                    finish_n = 1'b1;
                    state_n  = DONE;
                end
            end
            DONE: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (ctrl.abort && state != IDLE) begin
            sda_n    = SDA_RELEASE;
            busy_n   = 1'b0;
            finish_n = 1'b0;
            ack_n    = 1'b0;
            state_n  = IDLE;
        end
    end

    assign sda_out     = sda_q;
    assign ctrl.busy   = busy_q;
    assign ctrl.finish = finish_q;
    assign ctrl.ack_ok = ack_q;

endmodule

// File: tb/tb_i2c_slave_tx_byte_ctrl.sv
// Directed and random byte transfers checked against a simple
// bit-sequence model of the slave transmitter.
module tb_i2c_slave_tx_byte_ctrl;

    localparam int DW   = 8;
    localparam int SS   = 2;
    localparam int HALF = 8;

    logic clock = 1'b0;
    logic reset_n;
    logic scl;
    logic sda_in;
    logic sda_out;

    i2c_slave_tx_byte_ctrl_if #(.DATA_WIDTH(DW)) ctrl ();

    i2c_slave_tx_byte_ctrl #(
        .DATA_WIDTH  (DW),
        .SYNC_STAGES (SS)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .ctrl    (ctrl.slave),
        .scl     (scl),
        .sda_in  (sda_in),
        .sda_out (sda_out)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int fin_cnt  = 0;

    always @(negedge clock)
        if (ctrl.finish === 1'b1) fin_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse_go(input logic [DW-1:0] d);
        ctrl.data_in = d;
        ctrl.go      = 1'b1;
        tick(1);
        ctrl.go      = 1'b0;
        ctrl.data_in = DW'($urandom);
    endtask

    // SCL low phase: expected level must appear SS+1 clocks after the pin edge
    task automatic fall_expect(input logic exp, input string tag);
        logic prev;
        int   n;
        prev = sda_out;
        n    = 0;
        scl  = 1'b0;
        while (sda_out !== exp && n < HALF) begin
            tick(1);
            n++;
        end
        if (prev !== exp) chk({tag, "_lat"}, n, SS + 1);
        tick(HALF - n);
        chk(tag, sda_out, exp);
    endtask

    task automatic rise_expect(input logic exp, input string tag);
        scl = 1'b1;
        tick(HALF);
        chk({tag, "_hold"}, sda_out, exp);
    endtask

    task automatic send_byte(input logic [DW-1:0] d, input logic ack,
                             input int inj_at, input logic done_go,
                             input string tag);
        int   f0;
        int   n;
        logic b;
        f0 = fin_cnt;
        pulse_go(d);
        chk({tag, "_busy"}, ctrl.busy, 1'b1);
        chk({tag, "_ack0"}, ctrl.ack_ok, 1'b0);
        for (int i = 0; i < DW; i++) begin
            b = ((int'(d) >> (DW - 1 - i)) & 1) != 0;
            fall_expect(b, $sformatf("%s_bit%0d", tag, i));
            if (i == inj_at) begin
                pulse_go('0);
                chk({tag, "_inj_busy"}, ctrl.busy, 1'b1);
            end
            rise_expect(b, $sformatf("%s_bit%0d", tag, i));
        end
        sda_in = ack ? 1'b0 : 1'b1;
        fall_expect(1'b1, {tag, "_rel"});
        scl = 1'b1;
        n   = 0;
        while (ctrl.finish !== 1'b1 && n < HALF) begin
            tick(1);
            n++;
        end
        chk({tag, "_fin"}, ctrl.finish, 1'b1);
        chk({tag, "_fin_lat"}, n, SS + 1);
        chk({tag, "_ack"}, ctrl.ack_ok, ack);
        if (done_go) begin
            ctrl.data_in = '0;
            ctrl.go      = 1'b1;
        end
        tick(1);
        ctrl.go = 1'b0;
        chk({tag, "_fin_pulse"}, ctrl.finish, 1'b0);
        chk({tag, "_idle"}, ctrl.busy, 1'b0);
        chk({tag, "_ack_hold"}, ctrl.ack_ok, ack);
        chk({tag, "_fin_cnt"}, fin_cnt - f0, 1);
        chk({tag, "_sda_rel"}, sda_out, 1'b1);
        sda_in = 1'b1;
    endtask

    initial begin
        int f0;
        logic [DW-1:0] rd;
        logic          ra;

        ctrl.go      = 1'b0;
        ctrl.data_in = '0;
        ctrl.abort   = 1'b0;
        scl          = 1'b1;
        sda_in       = 1'b1;
        reset_n      = 1'b0;
        tick(3);
        chk("rst_sda", sda_out, 1'b1);
        chk("rst_busy", ctrl.busy, 1'b0);
        chk("rst_fin", ctrl.finish, 1'b0);
        chk("rst_ack", ctrl.ack_ok, 1'b0);
        reset_n = 1'b1;
        tick(4);

        send_byte(8'hA5, 1'b1, -1, 1'b0, "t1");
        send_byte(8'hFF, 1'b0, -1, 1'b0, "t2");
        send_byte(8'h3C, 1'b1, 2, 1'b0, "t3");

        f0 = fin_cnt;
        pulse_go(8'h81);
        fall_expect(1'b1, "t4_b0");
        rise_expect(1'b1, "t4_b0");
        fall_expect(1'b0, "t4_b1");
        rise_expect(1'b0, "t4_b1");
        fall_expect(1'b0, "t4_b2");
        ctrl.abort = 1'b1;
        tick(1);
        ctrl.abort = 1'b0;
        chk("t4_abort_sda", sda_out, 1'b1);
        chk("t4_abort_busy", ctrl.busy, 1'b0);
        chk("t4_abort_ack", ctrl.ack_ok, 1'b0);
        rise_expect(1'b1, "t4_post");
        for (int i = 0; i < 6; i++) begin
            fall_expect(1'b1, "t4_post");
            rise_expect(1'b1, "t4_post");
        end
        chk("t4_no_fin", fin_cnt - f0, 0);

        pulse_go(8'h00);
        for (int i = 0; i < 4; i++) begin
            fall_expect(1'b0, "t5_bit");
            rise_expect(1'b0, "t5_bit");
        end
        fall_expect(1'b0, "t5_bit4");
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_async_sda", sda_out, 1'b1);
        chk("t5_async_busy", ctrl.busy, 1'b0);
        chk("t5_async_ack", ctrl.ack_ok, 1'b0);
        tick(2);
        reset_n = 1'b1;
        scl     = 1'b1;
        tick(HALF);
        send_byte(8'h55, 1'b1, -1, 1'b0, "t5b");

        f0 = fin_cnt;
        send_byte(8'h12, 1'b1, -1, 1'b1, "t6a");
        send_byte(8'h34, 1'b0, -1, 1'b0, "t6b");
        chk("t6_two_fin", fin_cnt - f0, 2);

        for (int k = 0; k < 6; k++) begin
            rd = DW'($urandom);
            ra = 1'($urandom_range(0, 1));
            tick(1 + int'($urandom_range(0, 3)));
            send_byte(rd, ra, -1, 1'b0, $sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
